sam_rv32i_core: RTL and testbench

- Self-contained 5-stage pipelined RV32I integer core: IF, ID, EX, MEM, WB.
- Contains its own instruction ROM, 32x32 register file and word-addressed data RAM.
- Runs a fixed built-in program after reset.
- Exposes only the fetch PC (NPC) and the last register write-back value (WB_OUT) for system-level observation and bring-up.

---
 rtl/sam_rv32i_core.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_sam_rv32i_core.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sam_rv32i_core.sv
// Five-stage RV32I integer core (IF/ID/EX/MEM/WB) with built-in program ROM,
// 32x32 register file and word-addressed data RAM. No forwarding, no stalls.
module sam_rv32i_core #(
   parameter int          IMEM_WORDS = 64,
   parameter int          DMEM_WORDS = 64,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        RN,
   output logic [31:0] NPC,
   output logic [31:0] WB_OUT
);

   localparam int          IMEM_AW = $clog2(IMEM_WORDS);
   localparam int          DMEM_AW = $clog2(DMEM_WORDS);
   localparam logic [31:0] NOP     = 32'h0000_0013;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL
   } alu_op_e;

   function automatic logic [31:0] rom_word(input logic [IMEM_AW-1:0] idx);
      logic [31:0] w;
      case (32'(idx))
         32'd0:   w = 32'h0050_0093;  // addi x1,x0,5
         32'd1:   w = 32'h0030_0113;  // addi x2,x0,3
         32'd2:   w = 32'h0100_0293;  // addi x5,x0,16
         32'd3:   w = NOP;
         32'd4:   w = 32'h0020_81B3;  // add  x3,x1,x2
         32'd5:   w = 32'h4020_8233;  // sub  x4,x1,x2
         32'd6:   w = 32'h0032_A023;  // sw   x3,0(x5)
         32'd7:   w = 32'h0020_F333;  // and  x6,x1,x2
         32'd8:   w = 32'h0020_E3B3;  // or   x7,x1,x2
         32'd9:   w = 32'h0002_A403;  // lw   x8,0(x5)
         32'd10:  w = 32'h0010_8463;  // beq  x1,x1,+8
         32'd11:  w = 32'h0FF0_0493;  // addi x9,x0,255
         32'd12:  w = 32'h0020_C533;  // xor  x10,x1,x2
         32'd13:  w = 32'h0000_0063;  // beq  x0,x0,0
         default: w = NOP;
      endcase
      return w;
   endfunction

   logic [31:0] pc_r;
   logic [31:0] ifid_pc_r;
   logic [31:0] ifid_ir_r;
   logic [31:0] idex_pc_r;
   logic [31:0] idex_a_r;
   logic [31:0] idex_b_r;
   logic [31:0] idex_imm_r;
   logic [4:0]  idex_rd_r;
   logic [4:0]  idex_rs2_r;
   alu_op_e     idex_op_r;
   logic        idex_use_imm_r;
   logic        idex_we_r;
   logic        idex_mrd_r;
   logic        idex_mwr_r;
   logic        idex_br_r;
   logic        idex_bne_r;
   logic [31:0] exmem_alu_r;
   logic [4:0]  exmem_rd_r;
   logic [4:0]  exmem_rs2_r;
   logic        exmem_we_r;
   logic        exmem_mrd_r;
   logic        exmem_mwr_r;
   logic [31:0] memwb_data_r;
   logic [4:0]  memwb_rd_r;
   logic        memwb_we_r;
   logic [31:0] wb_out_r;
   logic [31:0] rf_r [32];
   logic [31:0] dmem_r [DMEM_WORDS];

   logic [31:0] if_ir_s;
   logic [6:0]  opcode_s;
   logic [4:0]  rd_s;
   logic [2:0]  funct3_s;
   logic [4:0]  rs1_s;
   logic [4:0]  rs2_s;
   logic [6:0]  funct7_s;
   logic [31:0] imm_i_s;
   logic [31:0] imm_s_s;
   logic [31:0] imm_b_s;
   logic [31:0] rs1_val_s;
   logic [31:0] rs2_val_s;
   alu_op_e     dec_op_s;
   logic [31:0] dec_imm_s;
   logic        dec_use_imm_s;
   logic        dec_we_s;
   logic        dec_mrd_s;
   logic        dec_mwr_s;
   logic        dec_br_s;
   logic        dec_bne_s;
   logic [31:0] alu_b_s;
   logic [31:0] alu_s;
   logic        br_taken_s;
   logic [31:0] br_target_s;
   logic [DMEM_AW-1:0] dmem_idx_s;
   logic [31:0] load_s;
   logic [31:0] st_data_s;
   logic [31:0] mem_result_s;

   assign if_ir_s = rom_word(pc_r[IMEM_AW+1:2]);

   assign opcode_s = ifid_ir_r[6:0];
   assign rd_s     = ifid_ir_r[11:7];
   assign funct3_s = ifid_ir_r[14:12];
   assign rs1_s    = ifid_ir_r[19:15];
   assign rs2_s    = ifid_ir_r[24:20];
   assign funct7_s = ifid_ir_r[31:25];
   assign imm_i_s  = {{20{ifid_ir_r[31]}}, ifid_ir_r[31:20]};
   assign imm_s_s  = {{20{ifid_ir_r[31]}}, ifid_ir_r[31:25], ifid_ir_r[11:7]};
   assign imm_b_s  = {{19{ifid_ir_r[31]}}, ifid_ir_r[31], ifid_ir_r[7],
                      ifid_ir_r[30:25], ifid_ir_r[11:8], 1'b0};

   // Write-through: a register being written back this cycle is seen by its reader.
   assign rs1_val_s = (rs1_s == 5'd0) ? 32'd0 :
                      (memwb_we_r && (memwb_rd_r == rs1_s)) ? memwb_data_r : rf_r[rs1_s];
   assign rs2_val_s = (rs2_s == 5'd0) ? 32'd0 :
                      (memwb_we_r && (memwb_rd_r == rs2_s)) ? memwb_data_r : rf_r[rs2_s];

   // Instruction decode into ALU op, immediate and stage controls.
   always_comb begin
      dec_op_s      = ALU_ADD;
      dec_imm_s     = 32'd0;
      dec_use_imm_s = 1'b0;
      dec_we_s      = 1'b0;
      dec_mrd_s     = 1'b0;
      dec_mwr_s     = 1'b0;
      dec_br_s      = 1'b0;
      dec_bne_s     = 1'b0;
      case (opcode_s)
         7'b0110011: begin
            dec_we_s = 1'b1;
            case ({funct7_s, funct3_s})
               {7'h00, 3'h0}: dec_op_s = ALU_ADD;
               {7'h20, 3'h0}: dec_op_s = ALU_SUB;
               {7'h00, 3'h7}: dec_op_s = ALU_AND;
               {7'h00, 3'h6}: dec_op_s = ALU_OR;
               {7'h00, 3'h4}: dec_op_s = ALU_XOR;
               {7'h00, 3'h2}: dec_op_s = ALU_SLT;
               {7'h00, 3'h1}: dec_op_s = ALU_SLL;
               {7'h00, 3'h5}: dec_op_s = ALU_SRL;
               default:       dec_we_s = 1'b0;
            endcase
         end
         7'b0010011: begin
            if (funct3_s == 3'h0) begin
               dec_imm_s     = imm_i_s;
               dec_use_imm_s = 1'b1;
               dec_we_s      = 1'b1;
            end else begin
               dec_we_s      = 1'b0;
            end
         end
         7'b0000011: begin
            if (funct3_s == 3'h2) begin
               dec_imm_s     = imm_i_s;
               dec_use_imm_s = 1'b1;
               dec_we_s      = 1'b1;
               dec_mrd_s     = 1'b1;
            end else begin
               dec_mrd_s     = 1'b0;
            end
         end
         7'b0100011: begin
            if (funct3_s == 3'h2) begin
               dec_imm_s     = imm_s_s;
               dec_use_imm_s = 1'b1;
               dec_mwr_s     = 1'b1;
            end else begin
               dec_mwr_s     = 1'b0;
            end
         end
         7'b1100011: begin
            dec_imm_s = imm_b_s;
            if (funct3_s == 3'h0) begin
               dec_br_s  = 1'b1;
            end else if (funct3_s == 3'h1) begin
               dec_br_s  = 1'b1;
               dec_bne_s = 1'b1;
            end else begin
               dec_br_s  = 1'b0;
            end
         end
         default: dec_we_s = 1'b0;
      endcase
   end

   assign alu_b_s = idex_use_imm_r ? idex_imm_r : idex_b_r;

   // Execute-stage ALU.
   always_comb begin
      alu_s = 32'd0;
      case (idex_op_r)
         ALU_ADD: alu_s = idex_a_r + alu_b_s;
         ALU_SUB: alu_s = idex_a_r - alu_b_s;
         ALU_AND: alu_s = idex_a_r & alu_b_s;
         ALU_OR:  alu_s = idex_a_r | alu_b_s;
         ALU_XOR: alu_s = idex_a_r ^ alu_b_s;
         ALU_SLT: alu_s = {31'd0, ($signed(idex_a_r) < $signed(alu_b_s))};
         ALU_SLL: alu_s = idex_a_r << alu_b_s[4:0];
         ALU_SRL: alu_s = idex_a_r >> alu_b_s[4:0];
         default: alu_s = idex_a_r + alu_b_s;
      endcase
   end

   assign br_taken_s  = idex_br_r & (idex_bne_r ? (idex_a_r != idex_b_r) : (idex_a_r == idex_b_r));
   assign br_target_s = idex_pc_r + idex_imm_r;

   assign dmem_idx_s   = exmem_alu_r[DMEM_AW+1:2];
   assign load_s       = dmem_r[dmem_idx_s];
   assign mem_result_s = exmem_mrd_r ? load_s : exmem_alu_r;

   // Store data is taken from the register file in MEM, so a value retiring
   // one slot ahead of the store is already committed when it is needed.
   assign st_data_s = (exmem_rs2_r == 5'd0) ? 32'd0 :
                      (memwb_we_r && (memwb_rd_r == exmem_rs2_r)) ? memwb_data_r : rf_r[exmem_rs2_r];

   // PC and pipeline registers; taken branch squashes IF/ID and ID/EX.
   always_ff @(posedge clk or negedge RN) begin
      if (!RN) begin
         pc_r           <= RESET_PC;
         ifid_pc_r      <= 32'd0;
         ifid_ir_r      <= NOP;
         idex_pc_r      <= 32'd0;
         idex_a_r       <= 32'd0;
         idex_b_r       <= 32'd0;
         idex_imm_r     <= 32'd0;
         idex_rd_r      <= 5'd0;
         idex_rs2_r     <= 5'd0;
         idex_op_r      <= ALU_ADD;
         idex_use_imm_r <= 1'b0;
         idex_we_r      <= 1'b0;
         idex_mrd_r     <= 1'b0;
         idex_mwr_r     <= 1'b0;
         idex_br_r      <= 1'b0;
         idex_bne_r     <= 1'b0;
         exmem_alu_r    <= 32'd0;
         exmem_rd_r     <= 5'd0;
         exmem_rs2_r    <= 5'd0;
         exmem_we_r     <= 1'b0;
         exmem_mrd_r    <= 1'b0;
         exmem_mwr_r    <= 1'b0;
         memwb_data_r   <= 32'd0;
         memwb_rd_r     <= 5'd0;
         memwb_we_r     <= 1'b0;
      end else begin
         if (br_taken_s) begin
            pc_r           <= br_target_s;
            ifid_pc_r      <= 32'd0;
            ifid_ir_r      <= NOP;
            idex_pc_r      <= 32'd0;
            idex_a_r       <= 32'd0;
            idex_b_r       <= 32'd0;
            idex_imm_r     <= 32'd0;
            idex_rd_r      <= 5'd0;
            idex_rs2_r     <= 5'd0;
            idex_op_r      <= ALU_ADD;
            idex_use_imm_r <= 1'b0;
            idex_we_r      <= 1'b0;
            idex_mrd_r     <= 1'b0;
            idex_mwr_r     <= 1'b0;
            idex_br_r      <= 1'b0;
            idex_bne_r     <= 1'b0;
         end else begin
            pc_r           <= pc_r + 32'd4;
            ifid_pc_r      <= pc_r;
            ifid_ir_r      <= if_ir_s;
            idex_pc_r      <= ifid_pc_r;
            idex_a_r       <= rs1_val_s;
            idex_b_r       <= rs2_val_s;
            idex_imm_r     <= dec_imm_s;
            idex_rd_r      <= rd_s;
            idex_rs2_r     <= rs2_s;
            idex_op_r      <= dec_op_s;
            idex_use_imm_r <= dec_use_imm_s;
            idex_we_r      <= dec_we_s;
            idex_mrd_r     <= dec_mrd_s;
            idex_mwr_r     <= dec_mwr_s;
            idex_br_r      <= dec_br_s;
            idex_bne_r     <= dec_bne_s;
         end
         exmem_alu_r  <= alu_s;
         exmem_rd_r   <= idex_rd_r;
         exmem_rs2_r  <= idex_rs2_r;
         exmem_we_r   <= idex_we_r;
         exmem_mrd_r  <= idex_mrd_r;
         exmem_mwr_r  <= idex_mwr_r;
         memwb_data_r <= mem_result_s;
         memwb_rd_r   <= exmem_rd_r;
         memwb_we_r   <= exmem_we_r;
      end
   end

   // Register file write-back and observed write-back value.
   always_ff @(posedge clk or negedge RN) begin
      if (!RN) begin
         for (int i = 0; i < 32; i++) begin
            rf_r[i] <= 32'd0;
         end
         wb_out_r <= 32'd0;
      end else if (memwb_we_r && (memwb_rd_r != 5'd0)) begin
         rf_r[memwb_rd_r] <= memwb_data_r;
         wb_out_r         <= memwb_data_r;
      end
   end

   // Data RAM store port.
   always_ff @(posedge clk or negedge RN) begin
      if (!RN) begin
         for (int i = 0; i < DMEM_WORDS; i++) begin
            dmem_r[i] <= 32'd0;
         end
      end else if (exmem_mwr_r) begin
         dmem_r[dmem_idx_s] <= st_data_s;
      end
   end

   assign NPC    = pc_r;
   assign WB_OUT = wb_out_r;

endmodule

// File: tb/tb_sam_rv32i_core.sv
// Bench for sam_rv32i_core: instruction-level reference model feeds a queue of
// expected write-backs and per-edge fetch PCs; a negedge monitor checks them.
module tb_sam_rv32i_core;

   logic        clk = 1'b0;
   logic        RN;
   logic [31:0] NPC;
   logic [31:0] WB_OUT;

   sam_rv32i_core dut (.clk(clk), .RN(RN), .NPC(NPC), .WB_OUT(WB_OUT));

   always #5 clk = ~clk;

   typedef struct {
      int          edge_no;
      logic [31:0] val;
   } wb_ev_t;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          base_cyc = 0;
   bit          running = 1'b0;
   logic [31:0] prev_wb = 32'd0;
   wb_ev_t      exp_q[$];
   logic [31:0] npc_exp [256];
   logic [31:0] prog [64];
   int          lens [4];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Architectural execution of the program; timing follows the pipeline rules:
   // write-back 4 edges after fetch, taken branch refetches 3 edges later.
   task automatic build_model(input int horizon);
      logic [31:0] regs [32];
      logic [31:0] mem [64];
      logic [31:0] pc, ir, a, b, val, next_pc, last, addr;
      logic [31:0] imm_i, imm_s, imm_b;
      logic [6:0]  opc, f7;
      logic [2:0]  f3;
      logic [4:0]  rd;
      bit          wr, taken;
      int          f;
      wb_ev_t      ev;
      for (int i = 0; i < 32; i++) regs[i] = 32'd0;
      for (int i = 0; i < 64; i++) mem[i] = 32'd0;
      for (int i = 0; i < 256; i++) npc_exp[i] = 32'hDEAD_BEEF;
      exp_q.delete();
      npc_exp[0] = 32'd0;
      pc = 32'd0; f = 1; last = 32'd0;
      while (f <= horizon) begin
         ir = prog[pc[7:2]];
         opc = ir[6:0]; rd = ir[11:7]; f3 = ir[14:12]; f7 = ir[31:25];
         a = regs[ir[19:15]]; b = regs[ir[24:20]];
         imm_i = 32'($signed(ir[31:20]));
         imm_s = 32'($signed({ir[31:25], ir[11:7]}));
         imm_b = 32'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
         wr = 1'b0; taken = 1'b0; val = 32'd0; next_pc = pc + 32'd4;
         case (opc)
            7'h33: begin
               wr = 1'b1;
               case ({f7, f3})
                  {7'h00, 3'd0}: val = a + b;
                  {7'h20, 3'd0}: val = a - b;
                  {7'h00, 3'd7}: val = a & b;
                  {7'h00, 3'd6}: val = a | b;
                  {7'h00, 3'd4}: val = a ^ b;
                  {7'h00, 3'd2}: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                  {7'h00, 3'd1}: val = a << b[4:0];
                  {7'h00, 3'd5}: val = a >> b[4:0];
                  default:       wr = 1'b0;
               endcase
            end
            7'h13: if (f3 == 3'd0) begin wr = 1'b1; val = a + imm_i; end
            7'h03: if (f3 == 3'd2) begin addr = a + imm_i; wr = 1'b1; val = mem[addr[7:2]]; end
            7'h23: if (f3 == 3'd2) begin addr = a + imm_s; mem[addr[7:2]] = b; end
            7'h63: begin
               taken = ((f3 == 3'd0) && (a == b)) || ((f3 == 3'd1) && (a != b));
               if (taken) next_pc = pc + imm_b;
            end
            default: ;
         endcase
         if (wr && (rd != 5'd0)) begin
            regs[rd] = val;
            if (val != last) begin
               ev.edge_no = f + 4; ev.val = val;
               exp_q.push_back(ev);
               last = val;
            end
         end
         npc_exp[f] = pc + 32'd4;
         if (taken) begin
            npc_exp[f+1] = pc + 32'd8;
            npc_exp[f+2] = next_pc;
            f += 3;
         end else begin
            f += 1;
         end
         pc = next_pc;
      end
   endtask

   // Monitor: per-edge fetch PC, and every WB_OUT change against the queue.
   always @(negedge clk) begin
      int     e;
      wb_ev_t ev;
      if (running) begin
         e = cyc - base_cyc;
         if (e < 256) check($sformatf("npc_e%0d", e), NPC, npc_exp[e]);
         if (WB_OUT !== prev_wb) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL wb_unexpected_e%0d: got %h expected no write", e, WB_OUT);
            end else begin
               ev = exp_q.pop_front();
               check("wb_value", WB_OUT, ev.val);
               check("wb_edge", 32'(e), 32'(ev.edge_no));
            end
            prev_wb = WB_OUT;
         end
      end else begin
         prev_wb = 32'd0;
      end
   end

   task automatic end_run_checks(input int n);
      check("npc_end", NPC, npc_exp[n]);
      checks++;
      if ((exp_q.size() > 0) && (exp_q[0].edge_no < n)) begin
         errors++;
         $display("FAIL wb_missing: got no write by edge %0d expected %h at edge %0d",
                  n, exp_q[0].val, exp_q[0].edge_no);
      end
      check("x9_never_written", dut.rf_r[9], 32'd0);
      if (n >= 12) check("dmem_word4", dut.dmem_r[4], 32'd8);
      if (n >= 15) check("x8_loaded", dut.rf_r[8], 32'd8);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) prog[i] = 32'h0000_0013;
      prog[0]  = 32'h0050_0093; prog[1]  = 32'h0030_0113; prog[2]  = 32'h0100_0293;
      prog[4]  = 32'h0020_81B3; prog[5]  = 32'h4020_8233; prog[6]  = 32'h0032_A023;
      prog[7]  = 32'h0020_F333; prog[8]  = 32'h0020_E3B3; prog[9]  = 32'h0002_A403;
      prog[10] = 32'h0010_8463; prog[11] = 32'h0FF0_0493; prog[12] = 32'h0020_C533;
      prog[13] = 32'h0000_0063;
      lens[0] = 30;
      lens[1] = 12;
      lens[2] = $urandom_range(15, 45);
      lens[3] = $urandom_range(8, 45);

      RN = 1'b0;
      build_model(70);
      repeat (2) @(posedge clk);
      #1;
      check("reset_npc", NPC, 32'd0);
      check("reset_wb", WB_OUT, 32'd0);

      for (int r = 0; r < 4; r++) begin
         @(negedge clk);
         #1;
         RN = 1'b1;
         base_cyc = cyc;
         running = 1'b1;
         repeat (lens[r]) @(posedge clk);
         #1;
         end_run_checks(lens[r]);
         #($urandom_range(1, 3));
         running = 1'b0;
         RN = 1'b0;
         #1;
         check("async_npc", NPC, 32'd0);
         check("async_wb", WB_OUT, 32'd0);
         build_model(70);
         repeat ($urandom_range(1, 3)) @(posedge clk);
         #1;
         check("held_npc", NPC, 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
